// File: rtl/io_port_pkg.sv
// Shared types and default channel map for the PicoBlaze port router.
// Channel order: RTC, teclado, VGA, sonido. Sonido overlaps RTC and VGA, so those two take priority.
package io_port_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int CH_RTC     = 0;
    localparam int CH_TECLADO = 1;
    localparam int CH_VGA     = 2;
    localparam int CH_SONIDO  = 3;

    // Places one byte per channel at its channel index inside a packed 4x8 table.
    function automatic logic [31:0] pack_ch4(input logic [7:0] v_rtc, input logic [7:0] v_teclado,
                                             input logic [7:0] v_vga, input logic [7:0] v_sonido);
        logic [31:0] r;
        r = '0;
        r[CH_RTC*8     +: 8] = v_rtc;
        r[CH_TECLADO*8 +: 8] = v_teclado;
        r[CH_VGA*8     +: 8] = v_vga;
        r[CH_SONIDO*8  +: 8] = v_sonido;
        return r;
    endfunction

    localparam logic [31:0] DEF_CH_BASE  = pack_ch4(8'd17, 8'd0,  8'd40, 8'd24);
    localparam logic [31:0] DEF_CH_LIMIT = pack_ch4(8'd28, 8'd15, 8'd51, 8'd63);
    localparam logic [31:0] DEF_CH_DOFS  = pack_ch4(8'd33, 8'd0,  8'd40, 8'h80);

    // Read data returned on a timed-out access (sliced to the data width).
    localparam logic [63:0] TIMEOUT_DATA = '1;

endpackage

// File: rtl/io_range_match.sv
// Combinational priority matcher: port id -> {hit, channel index, translated dir}.
// The lowest channel index whose [BASE, LIMIT] range contains the id wins.
module io_range_match #(
    parameter int              NCH      = 4,
    parameter int              AW       = 8,
    parameter int              IW       = 2,
    parameter logic [NCH*AW-1:0] CH_BASE  = '0,
    parameter logic [NCH*AW-1:0] CH_LIMIT = '0,
    parameter logic [NCH*AW-1:0] CH_DOFS  = '0
) (
    input  logic [AW-1:0] id,
    output logic          hit,
    output logic [IW-1:0] idx,
    output logic [AW-1:0] dir
);

    logic [NCH-1:0] in_range;
    logic [AW-1:0]  ch_dir [NCH];

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            assign in_range[gi] = (id >= CH_BASE[gi*AW +: AW]) && (id <= CH_LIMIT[gi*AW +: AW]);
            assign ch_dir[gi]   = id - CH_BASE[gi*AW +: AW] + CH_DOFS[gi*AW +: AW];
        end
    endgenerate

    // Scan from the top so the lowest matching index is the last one written.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        dir = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (in_range[i]) begin
                hit = 1'b1;
                idx = IW'(i);
                dir = ch_dir[i];
            end
        end
    end

endmodule

// File: rtl/io_port_router.sv
// Registered PicoBlaze port router: decode, one handshaked access per strobe, timeout, done pulse.
// Optional UNMAPPED_TRAP_EN adds sticky err/err_id with err_clr for unmapped or timed-out accesses.
module io_port_router
    import io_port_pkg::*;
#(
    parameter int                NCH      = 4,
    parameter int                AW       = 8,
    parameter int                DW       = 8,
    parameter logic [NCH*AW-1:0] CH_BASE  = DEF_CH_BASE,
    parameter logic [NCH*AW-1:0] CH_LIMIT = DEF_CH_LIMIT,
    parameter logic [NCH*AW-1:0] CH_DOFS  = DEF_CH_DOFS,
    parameter int                TO_CYC   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     port_id,
    input  logic              wr_strobe,
    input  logic              rd_strobe,
    input  logic [DW-1:0]     out_port,
    output logic [DW-1:0]     in_port,
    output logic              busy,
    output logic              done,
    output logic [NCH-1:0]    act,
    output logic [AW-1:0]     dir,
    output logic              per_wr,
    output logic              per_rd,
    output logic [DW-1:0]     per_wdata,
    input  logic [NCH*DW-1:0] per_rdata,
    input  logic [NCH-1:0]    per_ack
`ifdef UNMAPPED_TRAP_EN
    ,
    input  logic              err_clr,
    output logic              err,
    output logic [AW-1:0]     err_id
`endif
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = $clog2(TO_CYC + 1);

    state_t         state_reg, state_next;
    logic [AW-1:0]  id_reg;
    logic           wr_reg;
    logic [IW-1:0]  sel_reg;
    logic [CW-1:0]  cnt_reg;
    logic [DW-1:0]  in_port_reg, per_wdata_reg;
    logic [NCH-1:0] act_reg;
    logic [AW-1:0]  dir_reg;
    logic           per_wr_reg, per_rd_reg, busy_reg, done_reg;

    logic           m_hit;
    logic [IW-1:0]  m_idx;
    logic [AW-1:0]  m_dir;
    logic [DW-1:0]  rdata_ch [NCH];
    logic           strobe, ack_sel, to_last, finish;

    io_range_match #(
        .NCH(NCH), .AW(AW), .IW(IW),
        .CH_BASE(CH_BASE), .CH_LIMIT(CH_LIMIT), .CH_DOFS(CH_DOFS)
    ) u_match (
        .id(id_reg), .hit(m_hit), .idx(m_idx), .dir(m_dir)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_rdata
            assign rdata_ch[gi] = per_rdata[gi*DW +: DW];
        end
    endgenerate

    assign strobe  = wr_strobe | rd_strobe;
    assign ack_sel = per_ack[sel_reg];
    assign to_last = (cnt_reg == CW'(TO_CYC - 1));
    assign finish  = ack_sel | to_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (strobe) state_next = ST_DECODE;
            ST_DECODE: state_next = m_hit ? ST_ACCESS : ST_DONE;
            ST_ACCESS: if (finish) state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // A write wins over a simultaneous read; writes never touch in_port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_reg        <= '0;
            wr_reg        <= 1'b0;
            sel_reg       <= '0;
            cnt_reg       <= '0;
            in_port_reg   <= '0;
            per_wdata_reg <= '0;
            act_reg       <= '0;
            dir_reg       <= '0;
            per_wr_reg    <= 1'b0;
            per_rd_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: if (strobe) begin
                    id_reg        <= port_id;
                    wr_reg        <= wr_strobe;
                    per_wdata_reg <= out_port;
                    busy_reg      <= 1'b1;
                end
                ST_DECODE: begin
                    sel_reg <= m_idx;
                    dir_reg <= m_dir;
                    cnt_reg <= '0;
                    if (m_hit) begin
                        act_reg    <= NCH'(1) << m_idx;
                        per_wr_reg <= wr_reg;
                        per_rd_reg <= ~wr_reg;
                    end else begin
                        done_reg      <= 1'b1;
                        per_wdata_reg <= '0;
                        if (!wr_reg) in_port_reg <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (finish) begin
                        done_reg      <= 1'b1;
                        act_reg       <= '0;
                        per_wr_reg    <= 1'b0;
                        per_rd_reg    <= 1'b0;
                        per_wdata_reg <= '0;
                        if (!wr_reg) in_port_reg <= ack_sel ? rdata_ch[sel_reg] : TIMEOUT_DATA[DW-1:0];
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    done_reg <= 1'b0;
                    busy_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_port   = in_port_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign act       = act_reg;
    assign dir       = dir_reg;
    assign per_wr    = per_wr_reg;
    assign per_rd    = per_rd_reg;
    assign per_wdata = per_wdata_reg;

`ifdef UNMAPPED_TRAP_EN
    logic          err_reg;
    logic [AW-1:0] err_id_reg;
    logic          err_event;

    assign err_event = ((state_reg == ST_DECODE) && !m_hit) ||
                       ((state_reg == ST_ACCESS) && !ack_sel && to_last);

    // A new error in the same cycle as err_clr re-arms with the new id.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_reg    <= 1'b0;
            err_id_reg <= '0;
        end else if (err_event && (err_clr || !err_reg)) begin
            err_reg    <= 1'b1;
            err_id_reg <= id_reg;
        end else if (err_clr) begin
            err_reg    <= 1'b0;
            err_id_reg <= '0;
        end
    end

    assign err    = err_reg;
    assign err_id = err_id_reg;
`endif

endmodule

// File: tb/tb_io_port_router.sv
// Self-checking bench for io_port_router: directed scenarios plus randomized accesses
// checked against a range-table reference model. Handles UNMAPPED_TRAP_EN builds as well.
module tb_io_port_router;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  port_id;
    logic        wr_strobe, rd_strobe;
    logic [7:0]  out_port;
    logic [7:0]  in_port;
    logic        busy, done;
    logic [3:0]  act;
    logic [7:0]  dir;
    logic        per_wr, per_rd;
    logic [7:0]  per_wdata;
    logic [31:0] per_rdata;
    logic [3:0]  per_ack;
    logic [7:0]  rdata_tbl [4];
`ifdef UNMAPPED_TRAP_EN
    logic        err_clr;
    logic        err;
    logic [7:0]  err_id;
`endif

    int errors = 0;
    int checks = 0;
    logic [7:0] model_in = 8'h00;

    // Channel map as a plain table: RTC, teclado, VGA, sonido.
    int mb [4] = '{17, 0, 40, 24};
    int ml [4] = '{28, 15, 51, 63};
    int md [4] = '{33, 0, 40, 128};

    assign per_rdata = {rdata_tbl[3], rdata_tbl[2], rdata_tbl[1], rdata_tbl[0]};

    io_port_router #(.TO_CYC(TO)) dut (
        .clk(clk), .reset(reset), .port_id(port_id), .wr_strobe(wr_strobe), .rd_strobe(rd_strobe),
        .out_port(out_port), .in_port(in_port), .busy(busy), .done(done), .act(act), .dir(dir),
        .per_wr(per_wr), .per_rd(per_rd), .per_wdata(per_wdata), .per_rdata(per_rdata),
        .per_ack(per_ack)
`ifdef UNMAPPED_TRAP_EN
        , .err_clr(err_clr), .err(err), .err_id(err_id)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_decode(input int id, output bit hit, output int idx, output logic [7:0] d);
        hit = 1'b0; idx = 0; d = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (!hit && id >= mb[i] && id <= ml[i]) begin
                hit = 1'b1; idx = i; d = 8'((id - mb[i] + md[i]) % 256);
            end
        end
    endfunction

    // Drives one strobe and plays the peripheral; t counts cycles after the strobe cycle.
    task automatic run_txn(input logic [7:0] id, input bit wr, input bit rd, input logic [7:0] wdata,
                           input int ack_dly, input logic [3:0] ack_mask, input logic [3:0] noise,
                           input int inj_t,
                           output int lat, output int done_cnt, output int busy_cyc,
                           output logic [3:0] act_seen, output logic [7:0] dir_seen,
                           output int wr_cyc, output int rd_cyc, output logic [7:0] wdata_seen,
                           output logic [7:0] in_seen);
        int acc;
        lat = -1; done_cnt = 0; busy_cyc = 0; act_seen = 4'h0; dir_seen = 8'h00;
        wr_cyc = 0; rd_cyc = 0; wdata_seen = 8'h00; in_seen = 8'h00; acc = 0;
        port_id = id; out_port = wdata; wr_strobe = wr; rd_strobe = rd; per_ack = noise;
        step();
        wr_strobe = 1'b0; rd_strobe = 1'b0;
        for (int t = 1; t <= 60; t++) begin
            if (busy) busy_cyc++;
            if (act != 4'h0) begin act_seen |= act; dir_seen = dir; end
            if (per_wr) begin wr_cyc++; wdata_seen = per_wdata; end
            if (per_rd) rd_cyc++;
            if (done) begin
                done_cnt++;
                if (lat < 0) begin lat = t; in_seen = in_port; end
            end
            if (lat >= 0 && t >= lat + 4) break;
            per_ack = noise;
            if (per_rd || per_wr) begin
                if (acc == ack_dly) per_ack = per_ack | ack_mask;
                acc++;
            end
            wr_strobe = (t == inj_t);
            port_id   = (t == inj_t) ? 8'd18 : id;
            step();
        end
        wr_strobe = 1'b0; per_ack = 4'h0;
        $display("txn id=%0d wr=%0b rd=%0b ack_dly=%0d lat=%0d done=%0d act=%b dir=%0d in_port=%h",
                 id, wr, rd, ack_dly, lat, done_cnt, act_seen, dir_seen, in_seen);
    endtask

    task automatic test_reset();
        reset = 1'b1; port_id = 8'h00; wr_strobe = 1'b0; rd_strobe = 1'b0; out_port = 8'h00;
        per_ack = 4'h0;
        for (int i = 0; i < 4; i++) rdata_tbl[i] = 8'h00;
`ifdef UNMAPPED_TRAP_EN
        err_clr = 1'b0;
`endif
        #2;
        checks++;
        if ({in_port, act, dir, per_wr, per_rd, per_wdata, busy, done} !== 38'h0) begin
            errors++;
            $display("FAIL reset_outputs got in=%h act=%b dir=%h wr=%b rd=%b wd=%h busy=%b done=%b exp all 0",
                     in_port, act, dir, per_wr, per_rd, per_wdata, busy, done);
        end
        step(); step();
        reset = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_idle got busy=%b done=%b exp 0 0", busy, done);
        end
        $display("txn reset released");
    endtask

    task automatic test_read_rtc();
        int lat, dc, bc, wc, rc; logic [3:0] a; logic [7:0] d, wd, ip;
        rdata_tbl[0] = 8'h59; rdata_tbl[1] = 8'h11; rdata_tbl[2] = 8'h22; rdata_tbl[3] = 8'h33;
        run_txn(8'd17, 1'b0, 1'b1, 8'h00, 1, 4'b0001, 4'b0000, -1, lat, dc, bc, a, d, wc, rc, wd, ip);
        checks++; if (a !== 4'b0001) begin errors++; $display("FAIL rd17_act got=%b exp=0001", a); end
        checks++; if (d !== 8'd33)   begin errors++; $display("FAIL rd17_dir got=%0d exp=33", d); end
        checks++; if (ip !== 8'h59)  begin errors++; $display("FAIL rd17_in_port got=%h exp=59", ip); end
        checks++; if (lat !== 4)     begin errors++; $display("FAIL rd17_latency got=%0d exp=4", lat); end
        checks++; if (rc !== 2 || wc !== 0) begin errors++; $display("FAIL rd17_enables got rd=%0d wr=%0d exp rd=2 wr=0", rc, wc); end
        checks++; if (bc !== 4)      begin errors++; $display("FAIL rd17_busy got=%0d exp=4", bc); end
        model_in = 8'h59;
    endtask

    task automatic test_write_vga();
        int lat, dc, bc, wc, rc; logic [3:0] a; logic [7:0] d, wd, ip;
        run_txn(8'd41, 1'b1, 1'b0, 8'hA5, 0, 4'b0100, 4'b0000, -1, lat, dc, bc, a, d, wc, rc, wd, ip);
        checks++; if (wc !== 1 || rc !== 0) begin errors++; $display("FAIL wr41_enables got wr=%0d rd=%0d exp wr=1 rd=0", wc, rc); end
        checks++; if (wd !== 8'hA5) begin errors++; $display("FAIL wr41_wdata got=%h exp=a5", wd); end
        checks++; if (d !== 8'd41)  begin errors++; $display("FAIL wr41_dir got=%0d exp=41", d); end
        checks++; if (a !== 4'b0100) begin errors++; $display("FAIL wr41_act got=%b exp=0100", a); end
        checks++; if (lat !== 3)    begin errors++; $display("FAIL wr41_latency got=%0d exp=3", lat); end
        checks++; if (ip !== model_in) begin errors++; $display("FAIL wr41_in_port got=%h exp=%h", ip, model_in); end
    endtask

    task automatic test_unmapped();
        int lat, dc, bc, wc, rc; logic [3:0] a; logic [7:0] d, wd, ip;
        run_txn(8'd200, 1'b0, 1'b1, 8'h00, 0, 4'b1111, 4'b0000, -1, lat, dc, bc, a, d, wc, rc, wd, ip);
        checks++; if (a !== 4'b0000) begin errors++; $display("FAIL unmap_act got=%b exp=0000", a); end
        checks++; if (rc !== 0 || wc !== 0) begin errors++; $display("FAIL unmap_enables got rd=%0d wr=%0d exp 0 0", rc, wc); end
        checks++; if (ip !== 8'h00)  begin errors++; $display("FAIL unmap_in_port got=%h exp=00", ip); end
        checks++; if (lat !== 2)     begin errors++; $display("FAIL unmap_latency got=%0d exp=2", lat); end
        model_in = 8'h00;
`ifdef UNMAPPED_TRAP_EN
        checks++; if (err !== 1'b1 || err_id !== 8'd200) begin errors++; $display("FAIL unmap_err got err=%b id=%0d exp 1 200", err, err_id); end
        err_clr = 1'b1; step(); err_clr = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clr got=%b exp=0", err); end
`endif
    endtask

    task automatic test_timeout();
        int lat, dc, bc, wc, rc; logic [3:0] a; logic [7:0] d, wd, ip;
        run_txn(8'd5, 1'b0, 1'b1, 8'h00, -1, 4'b0010, 4'b0000, -1, lat, dc, bc, a, d, wc, rc, wd, ip);
        checks++; if (lat !== 2 + TO) begin errors++; $display("FAIL timeout_latency got=%0d exp=%0d", lat, 2 + TO); end
        checks++; if (ip !== 8'hFF)   begin errors++; $display("FAIL timeout_in_port got=%h exp=ff", ip); end
        checks++; if (rc !== TO)      begin errors++; $display("FAIL timeout_rd_cycles got=%0d exp=%0d", rc, TO); end
        checks++; if (a !== 4'b0010 || d !== 8'd5) begin errors++; $display("FAIL timeout_sel got act=%b dir=%0d exp 0010 5", a, d); end
        model_in = 8'hFF;
`ifdef UNMAPPED_TRAP_EN
        checks++; if (err !== 1'b1 || err_id !== 8'd5) begin errors++; $display("FAIL timeout_err got err=%b id=%0d exp 1 5", err, err_id); end
`endif
    endtask

    task automatic test_busy_ignore();
        int lat, dc, bc, wc, rc; logic [3:0] a; logic [7:0] d, wd, ip;
        rdata_tbl[0] = 8'h3C;
        run_txn(8'd20, 1'b0, 1'b1, 8'h00, 1, 4'b0001, 4'b1110, 3, lat, dc, bc, a, d, wc, rc, wd, ip);
        checks++; if (dc !== 1)     begin errors++; $display("FAIL busy_done_count got=%0d exp=1", dc); end
        checks++; if (lat !== 4)    begin errors++; $display("FAIL busy_latency got=%0d exp=4", lat); end
        checks++; if (ip !== 8'h3C) begin errors++; $display("FAIL busy_in_port got=%h exp=3c", ip); end
        checks++; if (bc !== 4 || wc !== 0) begin errors++; $display("FAIL busy_extra_access got busy=%0d wr=%0d exp 4 0", bc, wc); end
        model_in = 8'h3C;
    endtask

    task automatic test_random();
        int lat, dc, bc, wc, rc; logic [3:0] a; logic [7:0] d, wd, ip;
        bit hit; int idx; logic [7:0] edir, eip; int elat, ecyc, r, dly;
        logic [7:0] id, wdat; bit wr, rd; logic [3:0] mask, noise;
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 4; i++) rdata_tbl[i] = 8'($urandom);
            id   = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 70));
            wdat = 8'($urandom);
            r    = $urandom_range(0, 3);
            wr   = (r == 1 || r == 2); rd = (r != 1);
            r    = $urandom_range(0, 9);
            dly  = (r == 9) ? -1 : r % 6;
            model_decode(id, hit, idx, edir);
            mask  = hit ? 4'(1 << idx) : 4'h0;
            noise = 4'($urandom) & ~mask;
            run_txn(id, wr, rd, wdat, dly, mask, noise, -1, lat, dc, bc, a, d, wc, rc, wd, ip);
            if (!hit) begin
                elat = 2; ecyc = 0; eip = wr ? model_in : 8'h00;
            end else if (dly < 0) begin
                elat = 2 + TO; ecyc = TO; eip = wr ? model_in : 8'hFF;
            end else begin
                elat = 3 + dly; ecyc = dly + 1; eip = wr ? model_in : rdata_tbl[idx];
            end
            checks++; if (lat !== elat || dc !== 1) begin errors++; $display("FAIL rnd%0d_timing got lat=%0d done=%0d exp lat=%0d done=1", n, lat, dc, elat); end
            checks++; if (ip !== eip) begin errors++; $display("FAIL rnd%0d_in_port got=%h exp=%h", n, ip, eip); end
            checks++; if (a !== mask) begin errors++; $display("FAIL rnd%0d_act got=%b exp=%b", n, a, mask); end
            checks++; if (wc !== (wr ? ecyc : 0) || rc !== (wr ? 0 : ecyc)) begin
                errors++; $display("FAIL rnd%0d_enables got wr=%0d rd=%0d exp wr=%0d rd=%0d", n, wc, rc, wr ? ecyc : 0, wr ? 0 : ecyc);
            end
            checks++; if (bc !== elat) begin errors++; $display("FAIL rnd%0d_busy got=%0d exp=%0d", n, bc, elat); end
            if (hit) begin
                checks++; if (d !== edir) begin errors++; $display("FAIL rnd%0d_dir got=%0d exp=%0d", n, d, edir); end
                if (wr) begin
                    checks++; if (wd !== wdat) begin errors++; $display("FAIL rnd%0d_wdata got=%h exp=%h", n, wd, wdat); end
                end
            end
            model_in = eip;
        end
    endtask

    task automatic test_reset_mid_access();
        int dc;
        port_id = 8'd5; rd_strobe = 1'b1; out_port = 8'h77;
        step();
        rd_strobe = 1'b0;
        step(); step();
        checks++; if (per_rd !== 1'b1) begin errors++; $display("FAIL midrst_in_access got per_rd=%b exp=1", per_rd); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({in_port, act, dir, per_wr, per_rd, per_wdata, busy, done} !== 38'h0) begin
            errors++;
            $display("FAIL midrst_outputs got in=%h act=%b dir=%h wr=%b rd=%b wd=%h busy=%b done=%b exp all 0",
                     in_port, act, dir, per_wr, per_rd, per_wdata, busy, done);
        end
        step(); step();
        reset = 1'b0;
        dc = 0;
        for (int t = 0; t < 6; t++) begin
            if (done) dc++;
            step();
        end
        checks++; if (dc !== 0) begin errors++; $display("FAIL midrst_done_pulse got=%0d exp=0", dc); end
        model_in = 8'h00;
        $display("txn reset during access");
    endtask

    initial begin
        test_reset();
        test_read_rtc();
        test_write_vga();
        test_unmapped();
        test_timeout();
        test_busy_ignore();
        test_random();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
